// File: rtl/i2s_tx_controller.sv
// I2S transmit-side clock and sample controller: generates bclk/daclrc from clk and
// presents one 24-bit word per channel slot from a single-entry stereo holding buffer.
module i2s_tx_controller #(
  parameter int BCLK_HALF   = 11,
  parameter int BITS_PER_CH = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        s_valid,
  input  logic [23:0] s_left,
  input  logic [23:0] s_right,
  output logic        s_ready,
  input  logic        clear_underrun,
  output logic        bclk,
  output logic        daclrc,
  output logic [23:0] audio_data,
  output logic        busy,
  output logic        underrun,
  output logic [15:0] underrun_cnt
);

  typedef enum logic {IDLE, RUN} state_t;

  localparam logic [7:0] DIV_LAST = 8'(BCLK_HALF - 1);
  localparam logic [5:0] BIT_LAST = 6'(BITS_PER_CH - 1);

  state_t      state, state_next;
  logic [7:0]  div_cnt;
  logic [5:0]  bit_cnt;
  logic [23:0] buf_left, buf_right, active_right;
  logic        buf_full;

  logic transfer, bclk_fall, slot_end, frame_end, right_start, frame_load, stop, starved;

  assign s_ready     = !buf_full;
  assign busy        = (state == RUN);
  assign transfer    = s_valid && s_ready;
  assign bclk_fall   = (state == RUN) && (div_cnt == DIV_LAST) && bclk;
  assign slot_end    = bclk_fall && (bit_cnt == BIT_LAST);
  assign frame_end   = slot_end && daclrc;
  assign right_start = slot_end && !daclrc;
  assign stop        = frame_end && !enable;
  // A frame starts either when leaving IDLE or at the left-slot boundary while still enabled
  assign frame_load  = ((state == IDLE) && enable) || (frame_end && enable);
  assign starved     = frame_load && !buf_full;

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (enable) state_next = RUN;
      RUN:     if (stop)   state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      div_cnt      <= '0;
      bit_cnt      <= '0;
      bclk         <= 1'b0;
      daclrc       <= 1'b0;
      audio_data   <= '0;
      buf_left     <= '0;
      buf_right    <= '0;
      buf_full     <= 1'b0;
      active_right <= '0;
      underrun     <= 1'b0;
      underrun_cnt <= '0;
    end else begin
      if (transfer) begin
        buf_left  <= s_left;
        buf_right <= s_right;
        buf_full  <= 1'b1;
      end

      if (frame_load) begin
        if (buf_full) begin
          active_right <= buf_right;
          audio_data   <= buf_left;
          buf_full     <= 1'b0;
        end else begin
          active_right <= '0;
          audio_data   <= '0;
        end
      end else if (right_start) begin
        audio_data <= active_right;
      end

      // A new underrun takes priority over a coincident clear
      if (starved) begin
        underrun <= 1'b1;
        if (underrun_cnt != 16'hFFFF) underrun_cnt <= underrun_cnt + 16'd1;
      end else if (clear_underrun) begin
        underrun <= 1'b0;
      end

      if ((state == IDLE) || stop) begin
        div_cnt <= '0;
        bit_cnt <= '0;
        bclk    <= 1'b0;
        daclrc  <= 1'b0;
      end else begin
        if (div_cnt == DIV_LAST) begin
          div_cnt <= '0;
          bclk    <= !bclk;
        end else begin
          div_cnt <= div_cnt + 8'd1;
        end
        if (bclk_fall) begin
          if (bit_cnt == BIT_LAST) begin
            bit_cnt <= '0;
            daclrc  <= !daclrc;
          end else begin
            bit_cnt <= bit_cnt + 6'd1;
          end
        end
      end
    end
  end

endmodule
